// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - cpu data-port bus between the processor and the data-memory controller
interface dmem_access_ctrl_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        memwrite;
    logic        memread;
    logic [3:0]  sign_mask;
    logic [31:0] read_data;
    logic        clk_stall;

    modport master (
        output addr, write_data, memwrite, memread, sign_mask,
        input  read_data, clk_stall
    );

    modport slave (
        input  addr, write_data, memwrite, memread, sign_mask,
        output read_data, clk_stall
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - data-memory controller: sub-word loads/stores over a word BRAM, LED register, cpu stall
module dmem_access_ctrl #(
    parameter int          WORD_AW   = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter logic [31:0] LED_ADDR  = 32'h0000_2000
) (
    input  logic               clk,
    input  logic               rst,
    dmem_access_ctrl_if.slave  cpu,
    output logic [7:0]         led,
    output logic [WORD_AW-1:0] ram_addr,
    output logic [31:0]        ram_wdata,
    output logic               ram_we,
    input  logic [31:0]        ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t              state, state_n;
    logic [31:0]         a_addr, a_addr_n;
    logic [31:0]         a_wdata, a_wdata_n;
    logic [3:0]          a_mask, a_mask_n;
    logic                a_wr, a_wr_n;
    logic [31:0]         rd_q, rd_n;
    logic                stall_q, stall_n;
    logic [7:0]          led_q, led_n;
    logic [WORD_AW-1:0]  raddr_q, raddr_n;
    logic [31:0]         wdata_q, wdata_n;
    logic                we_q, we_n;

    // BASE_ADDR is word aligned, so the word offset is just the difference of the word parts.
    logic [29:0] off_word;
    logic        in_ram;
    logic        is_led;
    logic        is_byte;
    logic        is_half;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign off_word = a_addr[31:2] - BASE_ADDR[31:2];
    assign in_ram   = (a_addr >= BASE_ADDR) && ((off_word >> WORD_AW) == 30'd0);
    assign is_led   = (a_addr == LED_ADDR);
    assign is_byte  = (a_mask[2:0] == 3'b001);
    assign is_half  = (a_mask[2:0] == 3'b010);

    assign byte_lane = ram_rdata[{a_addr[1:0], 3'b000} +: 8];
    assign half_lane = a_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        load_val = ram_rdata;
        if (is_byte)
            load_val = {{24{byte_lane[7] & ~a_mask[3]}}, byte_lane};
        else if (is_half)
            load_val = {{16{half_lane[15] & ~a_mask[3]}}, half_lane};
    end

    always_comb begin
        merged = ram_rdata;
        if (is_byte)
            merged[{a_addr[1:0], 3'b000} +: 8] = a_wdata[7:0];
        else if (is_half)
            merged[{a_addr[1], 4'b0000} +: 16] = a_wdata[15:0];
        else
            merged = a_wdata;
    end

    always_comb begin
        state_n   = state;
        a_addr_n  = a_addr;
        a_wdata_n = a_wdata;
        a_mask_n  = a_mask;
        a_wr_n    = a_wr;
        rd_n      = rd_q;
        stall_n   = stall_q;
        led_n     = led_q;
        raddr_n   = raddr_q;
        wdata_n   = wdata_q;
        we_n      = we_q;
        case (state)
            S_IDLE: begin
                if (cpu.memread || cpu.memwrite) begin
                    a_addr_n  = cpu.addr;
                    a_wdata_n = cpu.write_data;
                    a_mask_n  = cpu.sign_mask;
                    a_wr_n    = cpu.memwrite;
                    stall_n   = 1'b1;
                    state_n   = S_REQ;
                end
            end
            S_REQ: begin
                if (in_ram) begin
                    raddr_n = off_word[WORD_AW-1:0];
                    state_n = S_RD;
                end else begin
                    if (a_wr && is_led)
                        led_n = a_wdata[7:0];
                    if (!a_wr)
                        rd_n = 32'd0;
                    state_n = S_DONE;
                end
            end
            S_RD: state_n = S_WAIT;
            S_WAIT: begin
                // Word stores still pass through the read so every RAM store has the same latency.
                if (a_wr) begin
                    wdata_n = merged;
                    we_n    = 1'b1;
                    state_n = S_WR;
                end else begin
                    rd_n    = load_val;
                    state_n = S_DONE;
                end
            end
            S_WR: begin
                we_n    = 1'b0;
                state_n = S_DONE;
            end
            S_DONE: begin
                stall_n = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a_addr  <= 32'd0;
            a_wdata <= 32'd0;
            a_mask  <= 4'd0;
            a_wr    <= 1'b0;
            rd_q    <= 32'd0;
            stall_q <= 1'b0;
            led_q   <= 8'd0;
            raddr_q <= '0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
        end else begin
            state   <= state_n;
            a_addr  <= a_addr_n;
            a_wdata <= a_wdata_n;
            a_mask  <= a_mask_n;
            a_wr    <= a_wr_n;
            rd_q    <= rd_n;
            stall_q <= stall_n;
            led_q   <= led_n;
            raddr_q <= raddr_n;
            wdata_q <= wdata_n;
            we_q    <= we_n;
        end
    end

    assign cpu.read_data = rd_q;
    assign cpu.clk_stall = stall_q;
    assign led           = led_q;
    assign ram_addr      = raddr_q;
    assign ram_wdata     = wdata_q;
    assign ram_we        = we_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl with a BRAM model and reference model
module tb_dmem_access_ctrl;

    localparam int          WORD_AW = 10;
    localparam int          DEPTH   = 1 << WORD_AW;
    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam logic [31:0] LEDA    = 32'h0000_2000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         led;
    logic [WORD_AW-1:0] ram_addr;
    logic [31:0]        ram_wdata;
    logic               ram_we;
    logic [31:0]        ram_rdata;
    logic               mem_clear = 1'b1;

    int checks   = 0;
    int failures = 0;
    int we_count = 0;

    logic [31:0] bram    [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [7:0]  ref_led;
    logic [31:0] exp_rd;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl #(
        .WORD_AW  (WORD_AW),
        .BASE_ADDR(BASE),
        .LED_ADDR (LEDA)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu      (bus.slave),
        .led      (led),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_we   (ram_we),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) bram[i] <= 32'd0;
            ram_rdata <= 32'd0;
        end else begin
            ram_rdata <= bram[ram_addr];
            if (ram_we) bram[ram_addr] <= ram_wdata;
        end
    end

    always @(posedge clk) if (ram_we) we_count <= we_count + 1;

    task automatic model_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m, output int exp_cyc, output int exp_we);
        longint unsigned la, w, v, lmask, nw;
        int size, sh, idx;
        la   = longint'(a);
        size = (m[2:0] == 3'b001) ? 1 : (m[2:0] == 3'b010) ? 2 : 4;
        sh   = (size == 1) ? 8 * int'(la % 4) : (size == 2) ? ((la % 4 >= 2) ? 16 : 0) : 0;
        if (la >= longint'(BASE) && (la - longint'(BASE)) / 4 < DEPTH) begin
            idx = int'((la - longint'(BASE)) / 4);
            w   = longint'(ref_mem[idx]);
            lmask = ((64'd1 << (8 * size)) - 1) << sh;
            if (wr) begin
                exp_cyc = 5;
                exp_we  = 1;
                nw = (w & ~lmask) | ((longint'(d) << sh) & lmask);
                ref_mem[idx] = nw[31:0];
            end else begin
                exp_cyc = 4;
                exp_we  = 0;
                v = (w >> sh) & ((64'd1 << (8 * size)) - 1);
                if (size < 4 && !m[3] && v >= (64'd1 << (8 * size - 1)))
                    v = v - (64'd1 << (8 * size));
                exp_rd = v[31:0];
            end
        end else begin
            exp_cyc = 2;
            exp_we  = 0;
            if (wr && a == LEDA) ref_led = d[7:0];
            if (!wr) exp_rd = 32'd0;
        end
    endtask

    task automatic dut_op(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, output int cyc);
        @(negedge clk);
        bus.addr       = a;
        bus.write_data = d;
        bus.sign_mask  = m;
        bus.memwrite   = wr;
        bus.memread    = rd;
        @(negedge clk);
        bus.memwrite = 1'b0;
        bus.memread  = 1'b0;
        cyc = 0;
        while (bus.clk_stall === 1'b1 && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic checked_op(input string name, input bit wr, input bit rd, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] m, output int cyc);
        int exp_cyc, exp_we, we0;
        model_op(wr, a, d, m, exp_cyc, exp_we);
        we0 = we_count;
        dut_op(wr, rd, a, d, m, cyc);
        checks += 4;
        if (cyc !== exp_cyc) begin
            failures++;
            $display("FAIL %s stall_cycles: got %0d expected %0d (addr %h)", name, cyc, exp_cyc, a);
        end
        if (bus.read_data !== exp_rd) begin
            failures++;
            $display("FAIL %s read_data: got %h expected %h (addr %h mask %h)", name, bus.read_data, exp_rd, a, m);
        end
        if (led !== ref_led) begin
            failures++;
            $display("FAIL %s led: got %h expected %h", name, led, ref_led);
        end
        if (we_count - we0 !== exp_we) begin
            failures++;
            $display("FAIL %s ram_we_pulses: got %0d expected %0d", name, we_count - we0, exp_we);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        bus.addr = 0; bus.write_data = 0; bus.sign_mask = 0;
        bus.memwrite = 0; bus.memread = 0;
        rst = 1'b1;
        mem_clear = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mem_clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        ref_led = 8'd0;
        exp_rd  = 32'd0;
        check_val("reset clk_stall", {31'd0, bus.clk_stall}, 32'd0);
        check_val("reset read_data", bus.read_data, 32'd0);
        check_val("reset led", {24'd0, led}, 32'd0);
        check_val("reset ram_we", {31'd0, ram_we}, 32'd0);
        check_val("reset ram_addr", {22'd0, ram_addr}, 32'd0);
        check_val("reset ram_wdata", ram_wdata, 32'd0);
    endtask

    task automatic test_rst_mid_store();
        int cyc, we0;
        checked_op("led_pre", 1, 0, LEDA, 32'h0000_005A, 4'b0100, cyc);
        checked_op("load_pre", 0, 1, BASE + 32'd8, 0, 4'b0100, cyc);
        we0 = we_count;
        @(negedge clk);
        bus.addr = BASE + 32'd8; bus.write_data = 32'hCAFE_F00D; bus.sign_mask = 4'b0001;
        bus.memwrite = 1'b1; bus.memread = 1'b0;
        @(negedge clk);
        bus.memwrite = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_led = 8'd0;
        exp_rd  = 32'd0;
        check_val("rst_mid clk_stall", {31'd0, bus.clk_stall}, 32'd0);
        check_val("rst_mid led", {24'd0, led}, 32'd0);
        check_val("rst_mid read_data", bus.read_data, 32'd0);
        repeat (3) @(negedge clk);
        check_val("rst_mid ram_we_pulses", we_count - we0, 32'd0);
        checked_op("rst_mid reload", 0, 1, BASE + 32'd8, 0, 4'b0100, cyc);
        check_val("rst_mid word kept", bus.read_data, 32'd0);
    endtask

    task automatic test_word_store_load();
        int cyc;
        checked_op("sw", 1, 0, 32'h1004, 32'hDEAD_BEEF, 4'b0100, cyc);
        check_val("sw latency", cyc, 5);
        checked_op("lw", 0, 1, 32'h1004, 0, 4'b0100, cyc);
        check_val("lw value", bus.read_data, 32'hDEAD_BEEF);
        check_val("lw latency", cyc, 4);
    endtask

    task automatic test_byte();
        int cyc;
        checked_op("sw base", 1, 0, 32'h1004, 32'h1122_3344, 4'b0100, cyc);
        checked_op("sb", 1, 0, 32'h1006, 32'h0000_0080, 4'b0001, cyc);
        checked_op("lw merged", 0, 1, 32'h1004, 0, 4'b0100, cyc);
        check_val("sb merged word", bus.read_data, 32'h1180_3344);
        checked_op("lb", 0, 1, 32'h1006, 0, 4'b0001, cyc);
        check_val("lb value", bus.read_data, 32'hFFFF_FF80);
        checked_op("lbu", 0, 1, 32'h1006, 0, 4'b1001, cyc);
        check_val("lbu value", bus.read_data, 32'h0000_0080);
    endtask

    task automatic test_half();
        int cyc;
        checked_op("sw zero", 1, 0, 32'h1000, 32'h0, 4'b0100, cyc);
        checked_op("sh", 1, 0, 32'h1002, 32'h0000_F00D, 4'b0010, cyc);
        checked_op("lw half", 0, 1, 32'h1000, 0, 4'b0100, cyc);
        check_val("sh merged word", bus.read_data, 32'hF00D_0000);
        checked_op("lh", 0, 1, 32'h1002, 0, 4'b0010, cyc);
        check_val("lh value", bus.read_data, 32'hFFFF_F00D);
        checked_op("lhu", 0, 1, 32'h1002, 0, 4'b1010, cyc);
        check_val("lhu value", bus.read_data, 32'h0000_F00D);
    endtask

    task automatic test_led();
        int cyc;
        checked_op("led sw", 1, 0, LEDA, 32'h0000_00A5, 4'b0100, cyc);
        check_val("led value", {24'd0, led}, 32'h0000_00A5);
        check_val("led latency", cyc, 2);
        checked_op("led lw", 0, 1, LEDA, 0, 4'b0100, cyc);
        check_val("led read zero", bus.read_data, 32'd0);
    endtask

    task automatic test_out_of_range();
        int cyc;
        checked_op("last sw", 1, 0, BASE + 4 * (DEPTH - 1), 32'h7777_1234, 4'b0100, cyc);
        checked_op("last lw", 0, 1, BASE + 4 * (DEPTH - 1), 0, 4'b0100, cyc);
        check_val("last word", bus.read_data, 32'h7777_1234);
        checked_op("oor lw", 0, 1, BASE + 4 * DEPTH, 0, 4'b0100, cyc);
        check_val("oor read zero", bus.read_data, 32'd0);
        check_val("oor latency", cyc, 2);
        checked_op("oor sw", 1, 0, BASE + 4 * DEPTH + 4, 32'h5555_5555, 4'b0100, cyc);
        checked_op("below lw", 0, 1, BASE - 4, 0, 4'b0100, cyc);
        checked_op("rw both", 1, 1, 32'h1010, 32'h1234_5678, 4'b0100, cyc);
        check_val("rw both latency", cyc, 5);
        checked_op("rw both lw", 0, 1, 32'h1010, 0, 4'b0100, cyc);
        check_val("rw both stored", bus.read_data, 32'h1234_5678);
    endtask

    task automatic test_random();
        int cyc;
        logic [31:0] a, d;
        logic [3:0]  m;
        bit wr, rd;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = BASE + $urandom_range(0, 63);
                4, 5:       a = BASE + 4 * DEPTH - 64 + $urandom_range(0, 63);
                6:          a = LEDA;
                7:          a = LEDA + $urandom_range(1, 63);
                8:          a = $urandom_range(0, BASE - 1);
                default:    a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: m = 4'b0001;
                1: m = 4'b1001;
                2: m = 4'b0010;
                3: m = 4'b1010;
                4: m = 4'b0100;
                default: m = 4'($urandom);
            endcase
            d  = $urandom;
            wr = 1'($urandom);
            rd = 1'($urandom);
            if (!wr && !rd) rd = 1'b1;
            checked_op("random", wr, rd, a, d, m, cyc);
        end
    endtask

    task automatic test_memory_image();
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (bram[i] !== ref_mem[i]) bad++;
        check_val("bram image mismatched words", bad, 0);
    endtask

    initial begin
        test_reset();
        test_rst_mid_store();
        test_word_store_load();
        test_byte();
        test_half();
        test_led();
        test_out_of_range();
        test_random();
        test_memory_image();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
